// File: rtl/seg595_scan_driver_if.sv
// Control/status and 74HC595 serial-bus bundle for seg595_scan_driver.
// The CPU side uses the master modport and the scan driver uses the slave modport.
interface seg595_scan_driver_if #(
  parameter int NUM_DIGITS = 8
);
  logic                    enable;
  logic [4*NUM_DIGITS-1:0] hex_data;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    lz_blank;
  logic                    clk;
  logic                    dat;
  logic                    str;
  logic                    busy;
  logic                    frame_done;

  modport master (
    output enable, hex_data, dp_mask, blank_mask, lz_blank,
    input  clk, dat, str, busy, frame_done
  );

  modport slave (
    input  enable, hex_data, dp_mask, blank_mask, lz_blank,
    output clk, dat, str, busy, frame_done
  );
endinterface

// File: rtl/seg595_scan_driver.sv
// Multiplexed 7-segment scanner that drives a chained 74HC595 pair over clk/dat/str.
// Each digit sends {segments, one-hot select} MSB first, latches it, then dwells.
module seg595_scan_driver #(
  parameter int NUM_DIGITS     = 8,
  parameter int CLK_DIV        = 2,
  parameter int DWELL          = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit SEL_ACTIVE_LOW = 1'b0
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  seg595_scan_driver_if.slave bus
);

  localparam int W       = 8 + NUM_DIGITS;
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BIT_W   = $clog2(W);
  localparam int CNT_MAX = (DWELL > CLK_DIV) ? DWELL : CLK_DIV;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]      DIV_LOAD   = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0]      DWELL_LOAD = CNT_W'((DWELL > 0) ? DWELL - 1 : 0);
  localparam logic [BIT_W-1:0]      BITS_LOAD  = BIT_W'(W - 1);
  localparam logic [IDX_W-1:0]      LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_XOR    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] SEL_XOR    = SEL_ACTIVE_LOW ? '1 : '0;
  localparam logic [W-1:0]          BLANK_WORD = {SEG_XOR, SEL_XOR};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT_LO,
    S_SHIFT_HI,
    S_STROBE,
    S_HOLD,
    S_BLANK
  } state_t;

  state_t                  state_reg, state_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [BIT_W-1:0]        bits_reg, bits_next;
  logic [W-1:0]            shift_reg, shift_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic                    blank_word_reg, blank_word_next;
  logic                    blank_sent_reg, blank_sent_next;
  logic                    dat_reg, dat_next;
  logic                    clk_reg, str_reg, busy_reg, frame_done_reg;
  logic                    frame_pulse;
  logic                    hold_exit;
  logic                    snap_en;

  logic [4*NUM_DIGITS-1:0] snap_hex_reg;
  logic [NUM_DIGITS-1:0]   snap_dp_reg;
  logic [NUM_DIGITS-1:0]   snap_blank_reg;
  logic [NUM_DIGITS-1:0]   snap_supp_reg;

  logic [NUM_DIGITS-1:0]   live_supp;
  logic [NUM_DIGITS-1:0]   sel_onehot;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic                    cur_supp;
  logic [7:0]              cur_seg;
  logic [W-1:0]            digit_word;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    return 7'h3F;
      4'h1:    return 7'h06;
      4'h2:    return 7'h5B;
      4'h3:    return 7'h4F;
      4'h4:    return 7'h66;
      4'h5:    return 7'h6D;
      4'h6:    return 7'h7D;
      4'h7:    return 7'h07;
      4'h8:    return 7'h7F;
      4'h9:    return 7'h6F;
      4'hA:    return 7'h77;
      4'hB:    return 7'h7C;
      4'hC:    return 7'h39;
      4'hD:    return 7'h5E;
      4'hE:    return 7'h79;
      default: return 7'h71;
    endcase
  endfunction

  // Leading-zero mask is taken from the live inputs at the same moment as the snapshot,
  // so it always describes the frame that is about to be shown.
  always_comb begin
    logic zero_run;
    zero_run  = 1'b1;
    live_supp = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run && (bus.hex_data[4*i +: 4] == 4'h0);
      if (i != 0) begin
        live_supp[i] = bus.lz_blank && zero_run;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_sel
      assign sel_onehot[gi] = (idx_reg == IDX_W'(gi));
    end
  endgenerate

  // Digit 0 reads the live inputs because its word is built in the very cycle the snapshot is taken.
  always_comb begin
    if (idx_reg == '0) begin
      cur_nib   = bus.hex_data[3:0];
      cur_dp    = bus.dp_mask[0];
      cur_blank = bus.blank_mask[0];
      cur_supp  = 1'b0;
    end else begin
      cur_nib   = snap_hex_reg[{idx_reg, 2'b00} +: 4];
      cur_dp    = snap_dp_reg[idx_reg];
      cur_blank = snap_blank_reg[idx_reg];
      cur_supp  = snap_supp_reg[idx_reg];
    end
    if (cur_blank) begin
      cur_seg = 8'h00;
    end else if (cur_supp) begin
      cur_seg = {cur_dp, 7'h00};
    end else begin
      cur_seg = {cur_dp, hex_to_seg(cur_nib)};
    end
  end

  assign digit_word = {cur_seg ^ SEG_XOR, sel_onehot ^ SEL_XOR};

  always_comb begin
    state_next      = state_reg;
    cnt_next        = cnt_reg;
    bits_next       = bits_reg;
    shift_next      = shift_reg;
    idx_next        = idx_reg;
    blank_word_next = blank_word_reg;
    blank_sent_next = blank_sent_reg;
    dat_next        = dat_reg;
    frame_pulse     = 1'b0;
    hold_exit       = 1'b0;
    snap_en         = 1'b0;

    case (state_reg)
      S_IDLE: begin
        dat_next = 1'b0;
        if (bus.enable) begin
          idx_next   = '0;
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        snap_en         = (idx_reg == '0);
        shift_next      = digit_word;
        dat_next        = digit_word[W-1];
        bits_next       = BITS_LOAD;
        cnt_next        = DIV_LOAD;
        blank_word_next = 1'b0;
        blank_sent_next = 1'b0;
        state_next      = S_SHIFT_LO;
      end
      S_BLANK: begin
        shift_next      = BLANK_WORD;
        dat_next        = BLANK_WORD[W-1];
        bits_next       = BITS_LOAD;
        cnt_next        = DIV_LOAD;
        blank_word_next = 1'b1;
        state_next      = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        if (cnt_reg == '0) begin
          cnt_next   = DIV_LOAD;
          state_next = S_SHIFT_HI;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      S_SHIFT_HI: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (bits_reg != '0) begin
          shift_next = shift_reg << 1;
          dat_next   = shift_reg[W-2];
          bits_next  = bits_reg - 1'b1;
          cnt_next   = DIV_LOAD;
          state_next = S_SHIFT_LO;
        end else begin
          dat_next   = 1'b0;
          cnt_next   = DIV_LOAD;
          state_next = S_STROBE;
        end
      end
      S_STROBE: begin
        if (cnt_reg != '0) begin
          cnt_next = cnt_reg - 1'b1;
        end else if (blank_word_reg) begin
          blank_sent_next = 1'b1;
          state_next      = S_IDLE;
        end else if (DWELL == 0) begin
          hold_exit = 1'b1;
        end else begin
          cnt_next   = DWELL_LOAD;
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_reg == '0) begin
          hold_exit = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // End of a digit's dwell: advance the scan, or wind down with one dark word.
    if (hold_exit) begin
      frame_pulse = (idx_reg == LAST_IDX);
      idx_next    = (idx_reg == LAST_IDX) ? '0 : idx_reg + 1'b1;
      if (bus.enable) begin
        state_next = S_LOAD;
      end else if (blank_sent_reg) begin
        state_next = S_IDLE;
      end else begin
        state_next = S_BLANK;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg      <= S_IDLE;
      cnt_reg        <= '0;
      bits_reg       <= '0;
      shift_reg      <= '0;
      idx_reg        <= '0;
      blank_word_reg <= 1'b0;
      blank_sent_reg <= 1'b0;
      dat_reg        <= 1'b0;
      clk_reg        <= 1'b0;
      str_reg        <= 1'b0;
      busy_reg       <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cnt_reg        <= cnt_next;
      bits_reg       <= bits_next;
      shift_reg      <= shift_next;
      idx_reg        <= idx_next;
      blank_word_reg <= blank_word_next;
      blank_sent_reg <= blank_sent_next;
      dat_reg        <= dat_next;
      clk_reg        <= (state_next == S_SHIFT_HI);
      str_reg        <= (state_next == S_STROBE);
      busy_reg       <= (state_next != S_IDLE);
      frame_done_reg <= frame_pulse;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (snap_en) begin
      snap_hex_reg   <= bus.hex_data;
      snap_dp_reg    <= bus.dp_mask;
      snap_blank_reg <= bus.blank_mask;
      snap_supp_reg  <= live_supp;
    end
  end

  assign bus.clk        = clk_reg;
  assign bus.dat        = dat_reg;
  assign bus.str        = str_reg;
  assign bus.busy       = busy_reg;
  assign bus.frame_done = frame_done_reg;

endmodule

// File: doc/seg595_scan_driver.md
Name: seg595_scan_driver

Overview:
- Parametrised successor to the fixed 4-byte hex 74HC595 display driver.
- Drives a chained 74HC595 pair over a 3-wire serial bus (clk/dat/str): one segment byte plus one digit-select field.
- Scans NUM_DIGITS multiplexed 7-segment digits with hex decode, per-digit decimal point, per-digit blanking, optional leading-zero suppression and configurable polarity.
- Sits between CPU debug/status registers and the board's segment-LED header.

Parameters:
- NUM_DIGITS, 8: number of digits scanned, 1..8; select field width.
- CLK_DIV, 2: sys_clk cycles per half period of clk, >=1.
- DWELL, 1000: sys_clk cycles each digit stays latched before the next shift starts, >=0.
- SEG_ACTIVE_LOW, 1: 1 inverts all 8 segment bits at the output.
- SEL_ACTIVE_LOW, 0: 1 inverts the select field at the output.

Ports:
- sys_clk, in, 1: system clock.
- sys_rst, in, 1: synchronous active-high reset.
- enable, in, 1: scan enable.
- hex_data, in, 4*NUM_DIGITS: nibble i = digit i; digit 0 is rightmost/least significant.
- dp_mask, in, NUM_DIGITS: bit i lights the decimal point of digit i.
- blank_mask, in, NUM_DIGITS: bit i forces digit i fully dark, including dp.
- lz_blank, in, 1: enables leading-zero suppression.
- clk, out, 1: 595 shift clock.
- dat, out, 1: 595 serial data.
- str, out, 1: 595 storage/latch strobe.
- busy, out, 1: high when not in IDLE.
- frame_done, out, 1: one-cycle pulse after the DWELL of digit NUM_DIGITS-1 completes.

Behaviour:
- One clock domain, sys_clk. sys_rst is synchronous and active-high.
- Reset: clk=0, dat=0, str=0, busy=0, frame_done=0, digit index=0, state=IDLE. Reset mid-shift takes effect on the next edge with no partial-frame completion.
- Segment code, internal active-high, bits {dp,g,f,e,d,c,b,a}:
  - 0..F = 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
  - dp = dp_mask[i].
  - Blanked digit = 00.
- Leading-zero suppression (lz_blank=1): starting from digit NUM_DIGITS-1 and moving downward, zero nibbles are blanked until the first nonzero nibble. Digit 0 is never suppressed. The dp of a suppressed digit still follows dp_mask.
- Select field: one-hot, bit i set for digit i.
- Shift word: {seg[7:0], sel[NUM_DIGITS-1:0]} after polarity inversion, 8+NUM_DIGITS bits, shifted MSB first.
- Snapshot: hex_data, dp_mask, blank_mask and lz_blank are captured only in LOAD when digit index=0. Input changes mid-frame have no effect until the next frame (no tearing).
- States:
  - IDLE: clk=0, str=0. If enable=1, go to LOAD.
  - LOAD, 1 cycle: build shift word for the current digit (snapshot first if index=0); dat<=MSB; go to SHIFT_LO.
  - SHIFT_LO, CLK_DIV cycles: clk=0, dat stable; go to SHIFT_HI.
  - SHIFT_HI, CLK_DIV cycles: clk=1. Then, if more bits remain, present next bit on dat and go to SHIFT_LO; else go to STROBE.
  - STROBE, CLK_DIV cycles: clk=0, str=1, dat=0; then go to HOLD.
  - HOLD, DWELL cycles: str=0. Then:
    - frame_done pulses if index=NUM_DIGITS-1.
    - index increments, wrapping NUM_DIGITS-1 -> 0.
    - If enable=1, go to LOAD.
    - Else go to BLANK, or to IDLE if the blank frame was already sent.
  - BLANK: shifts one all-off word (seg=00, sel=0, after polarity inversion) using the SHIFT/STROBE timing, then goes to IDLE. This clears the display when scanning stops.
- enable dropping mid-digit never aborts: the current digit completes through HOLD first.
- enable rising in IDLE: LOAD on the next cycle with index=0.
- Per-digit period = 1 + 2*CLK_DIV*(8+NUM_DIGITS) + CLK_DIV + DWELL cycles. Defaults: 1+64+2+1000 = 1067.
- Data changes only while clk=0; the 595 samples on the clk rising edge.

Test Plan:
- Reset, then enable=1, NUM_DIGITS=8, CLK_DIV=2, DWELL=10, SEG_ACTIVE_LOW=0, SEL_ACTIVE_LOW=0, hex_data=32'h0000_00A5 -> digit 0 word 16'h6D01 and digit 1 word 16'h7702. Next LOAD starts 77 cycles after the first.
- Same setup, lz_blank=1 -> digits 2..7 shift seg=00; digit 0 still shows 6D. With hex_data=0, digit 0 shows 3F and the rest 00.
- dp_mask=8'h04, blank_mask=8'h02, SEG_ACTIVE_LOW=1 -> digit 2 segment byte = ~(code|80); digit 1 = FF.
- hex_data changed while digit 3 is shifting -> digits 4..7 show old values; new values appear from the next digit 0. frame_done pulses exactly once per 8 digits.
- enable dropped during digit 5 SHIFT -> digit 5 completes, then one blank word (seg FF / sel 00 with SEG_ACTIVE_LOW=1) is shifted, then busy=0.
- sys_rst asserted mid-SHIFT_HI -> next cycle clk=dat=str=0, busy=0. After release with enable=1, scanning restarts at digit 0.
